// File: rtl/wr_burst_packer.sv
// Packs BURST_LEN beats popped from the write-data FIFO into one wide burst word,
// with a flush path that emits a partial burst and a per-beat valid mask.
module wr_burst_packer #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_rempty,
  output logic                       fifo_rinc,
  input  logic [WIDTH-1:0]           fifo_rdata,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*BURST_LEN-1:0] out_data,
  output logic [BURST_LEN-1:0]       out_mask,
  output logic                       busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(BURST_LEN);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     state, state_next;
  logic [CW-1:0]              issued, issued_next;
  logic [CW-1:0]              captured, captured_next;
  logic                       inflight;
  logic                       flush_pend, flush_pend_next;
  logic                       flush_done_q, flush_done_next;
  logic [WIDTH*BURST_LEN-1:0] data_q, data_next;
  logic [BURST_LEN-1:0]       mask_q, mask_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      issued       <= '0;
      captured     <= '0;
      inflight     <= 1'b0;
      flush_pend   <= 1'b0;
      flush_done_q <= 1'b0;
      data_q       <= '0;
      mask_q       <= '0;
    end else begin
      state        <= state_next;
      issued       <= issued_next;
      captured     <= captured_next;
      inflight     <= fifo_rinc;
      flush_pend   <= flush_pend_next;
      flush_done_q <= flush_done_next;
      data_q       <= data_next;
      mask_q       <= mask_next;
    end
  end

  always_comb begin
    state_next      = state;
    issued_next     = issued;
    captured_next   = captured;
    flush_pend_next = flush_pend;
    flush_done_next = 1'b0;
    data_next       = data_q;
    mask_next       = mask_q;
    fifo_rinc       = (state == FILL) && !fifo_rempty && (issued < FULL) && !flush_pend;

    case (state)
      FILL: begin
        if (fifo_rinc) issued_next = issued + 1'b1;

        if (inflight) begin
          for (int k = 0; k < BURST_LEN; k++) begin
            if (captured == CW'(k)) begin
              data_next[k*WIDTH +: WIDTH] = fifo_rdata;
              mask_next[k]                = 1'b1;
            end
          end
          captured_next = captured + 1'b1;
        end

        // A flush arriving with the final pop is moot: the burst completes anyway.
        if (flush_req && !flush_pend && (issued_next != FULL)) begin
          if ((captured == '0) && !inflight && !fifo_rinc) flush_done_next = 1'b1;
          else                                             flush_pend_next = 1'b1;
        end

        if (captured_next == FULL) begin
          state_next = HOLD;
        end else if (flush_pend && !inflight) begin
          if (captured != '0) begin
            state_next = HOLD;
          end else begin
            flush_pend_next = 1'b0;
            flush_done_next = 1'b1;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_next      = FILL;
          issued_next     = '0;
          captured_next   = '0;
          data_next       = '0;
          mask_next       = '0;
          flush_pend_next = 1'b0;
          flush_done_next = flush_pend;
        end
      end

      default: state_next = FILL;
    endcase
  end

  assign out_valid  = (state == HOLD);
  assign out_data   = data_q;
  assign out_mask   = mask_q;
  assign flush_done = flush_done_q;
  assign busy       = (captured != '0) || inflight || (state == HOLD);

endmodule
